ram_loader: RTL and testbench
=============================

RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter: DEPTH, 16, number of RAM bytes to load (power of two).
REQ-002 Parameter: ADDR_W, 4, address width, equal to log2(DEPTH).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  single-cycle request to begin a load; honoured only in IDLE.
REQ-006 byte_valid  in  1  source presents byte_data this cycle.
REQ-007 byte_data  in  8  program byte, in address order starting at 0.
REQ-008 byte_ready  out  1  loader accepts a byte this cycle.
REQ-009 ram_we  out  1  write strobe to the 16x8 RAM.
REQ-010 ram_addr  out  ADDR_W  RAM address, shared by write and read-back.
REQ-011 ram_wdata  out  8  RAM write data.
REQ-012 ram_rdata  in  8  RAM read data, registered in the RAM (1-cycle latency).
REQ-013 loading  out  1  high from start acceptance until DONE; holds the CPU halted.
REQ-014 done  out  1  one-cycle pulse when the load finishes.
REQ-015 error  out  1  sticky read-back mismatch flag; cleared by accepted start or reset.

Function
REQ-016 FSM states: IDLE, WRITE, VERIFY, CHECK, DONE.
REQ-017 IDLE -> WRITE on start; clears addr counter, checksum, error; loading rises the next cycle.
REQ-018 WRITE: byte_ready=1; handshake = byte_valid & byte_ready.
REQ-019 On handshake (same cycle, combinational): ram_we=1, ram_wdata=byte_data, ram_addr=addr; at the edge, addr+=1 and checksum+=byte_data mod 256.
REQ-020 byte_valid low in WRITE: ram_we=0, no counter change, no timeout.
REQ-021 Handshake at addr=DEPTH-1: addr wraps to 0; next state VERIFY if verify compiled in, else DONE.
REQ-022 VERIFY: ram_we=0; drives ram_addr 0..DEPTH-1 on consecutive cycles; accumulates ram_rdata one cycle after each address; after the last issue goes to CHECK, which absorbs the final read (DEPTH+1 cycles total).
REQ-023 CHECK: if readback sum != checksum, set error; -> DONE.
REQ-024 DONE: done=1 for exactly one cycle, loading=0; -> IDLE.
REQ-025 start outside IDLE is ignored; byte_valid outside WRITE is ignored (byte_ready=0).
REQ-026 ram_we is never high outside WRITE; ram_addr=0 and ram_wdata=0 whenever ram_we=0 in IDLE/DONE.

Reset
REQ-027 On rst_n=0 at an edge: state=IDLE, addr=0, checksum=0, error=0, done=0, loading=0, byte_ready=0, ram_we=0.
REQ-028 Reset mid-WRITE or mid-VERIFY aborts; no further RAM writes occur; a new start is required.

Configuration
REQ-029 Macro RAM_LOADER_VERIFY_EN: defined -> VERIFY/CHECK present and error operative; undefined -> WRITE goes directly to DONE, VERIFY/CHECK logic absent, error tied 0.

Structure
REQ-030 Shared package sap_pkg holds the loader state enum, RAM_DEPTH=16 and RAM_ADDR_W=4 constants.
REQ-031 No sub-module; checksum and address counter inline. The bench instantiates the existing 16x8 RAM as the load target.

Verification
REQ-032 Load 1F,4E,E0,FF,00x10,0A,0F with byte_valid held high -> 16 writes on consecutive cycles to addr 0..15, checksum 0x65, error=0, done one pulse, RAM matches.
REQ-033 byte_valid toggles 1/0 every cycle -> writes only on valid cycles; final RAM contents identical to REQ-032.
REQ-034 Bench corrupts RAM[5] to 0x01 between WRITE and VERIFY -> error=1 at DONE, remains 1 until next start.
REQ-035 rst_n low after 7 bytes -> loading=0 and ram_we=0 the next cycle; RAM[0..6] written, RAM[7..15] unchanged.
REQ-036 start pulsed during WRITE, byte_valid during IDLE -> no effect; address sequence unchanged.
REQ-037 Build without RAM_LOADER_VERIFY_EN -> done follows the 16th write by one cycle; error stays 0.

Source files
------------

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared loader state encoding and program RAM geometry
package sap_pkg;

    localparam int RAM_DEPTH  = 16;
    localparam int RAM_ADDR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_VERIFY,
        ST_CHECK,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - streams program bytes into RAM, optional read-back verify
// Optional feature macro: RAM_LOADER_VERIFY_EN (VERIFY/CHECK states and error flag)
module ram_loader
    import sap_pkg::*;
#(
    parameter int DEPTH  = RAM_DEPTH,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              loading,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_checksum;
    logic              w_hs;
    logic              w_last;
    logic              w_rd_issue;

    // Gating with rst_n keeps the reset-asserted cycle free of RAM writes.
    assign byte_ready = (r_state == ST_WRITE) && rst_n;
    assign w_hs       = byte_ready && byte_valid;
    assign w_last     = (r_addr == LAST_ADDR);
    assign ram_we     = w_hs;
    assign ram_wdata  = w_hs ? byte_data : 8'h00;
    assign ram_addr   = (w_hs || w_rd_issue) ? r_addr : '0;
    assign loading    = (r_state == ST_WRITE) || (r_state == ST_VERIFY) || (r_state == ST_CHECK);
    assign done       = (r_state == ST_DONE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_WRITE;
            ST_WRITE: begin
                if (w_hs && w_last) begin
`ifdef RAM_LOADER_VERIFY_EN
                    w_next = ST_VERIFY;
`else
                    w_next = ST_DONE;
`endif
                end
            end
`ifdef RAM_LOADER_VERIFY_EN
            ST_VERIFY: if (w_last) w_next = ST_CHECK;
            ST_CHECK:  w_next = ST_DONE;
`endif
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_checksum <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && start) begin
                r_addr     <= '0;
                r_checksum <= 8'h00;
            end else if (w_hs) begin
                r_addr     <= r_addr + 1'b1;
                r_checksum <= r_checksum + byte_data;
            end else if (w_rd_issue) begin
                r_addr     <= r_addr + 1'b1;
            end
        end
    end

`ifdef RAM_LOADER_VERIFY_EN
    logic [7:0] r_rdsum;
    logic       r_error;
    logic [7:0] w_final_sum;

    assign w_rd_issue  = (r_state == ST_VERIFY);
    assign w_final_sum = r_rdsum + ram_rdata;
    assign error       = r_error;

    // Read data lags the address by one cycle: the read of address 0 is
    // skipped here and the last read is folded in during CHECK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdsum <= 8'h00;
            r_error <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_rdsum <= 8'h00;
            r_error <= 1'b0;
        end else if (r_state == ST_VERIFY && r_addr != '0) begin
            r_rdsum <= w_final_sum;
        end else if (r_state == ST_CHECK && w_final_sum != r_checksum) begin
            r_error <= 1'b1;
        end
    end
`else
    logic [7:0] w_unused_rdata;

    assign w_rd_issue     = 1'b0;
    assign error          = 1'b0;
    assign w_unused_rdata = ram_rdata;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - scoreboard bench for ram_loader with a 16x8 registered-read RAM model
module tb_ram_loader;
    import sap_pkg::*;

`ifdef RAM_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       loading;
    logic       done;
    logic       error;

    logic       tb_we;
    logic [3:0] tb_waddr;
    logic [7:0] tb_wdata;
    logic [7:0] mem [16];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [15:0][7:0] data;
        bit               toggle;
        bit               corrupt;
        bit               noise;
        bit               exp_err;
    } scen_t;
    scen_t tbl[4];
    bit    prev_err;

    always #5 clk = ~clk;

    ram_loader #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .loading    (loading),
        .done       (done),
        .error      (error)
    );

    // Load target: registered read, bench back-door port for preload/corruption.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= ram_wdata;
        else if (tb_we)
            mem[tb_waddr] <= tb_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(ram_addr), 32'(e.addr));
                check("write_data", 32'(ram_wdata), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int a = 0; a < 16; a++) begin
            tb_we    = 1'b1;
            tb_waddr = 4'(a);
            tb_wdata = v;
            tick();
        end
        tb_we = 1'b0;
    endtask

    task automatic run_load(input int i);
        int k;
        int cyc;
        int lat;
        logic [7:0] exp_b;
        fill(8'h5A ^ 8'(i));
        check("error_held_before_start", 32'(error), 32'(prev_err));
        if (tbl[i].noise) begin
            for (int n = 0; n < 3; n++) begin
                byte_valid = 1'b1;
                byte_data  = 8'hEE;
                #1;
                check("idle_byte_ready", 32'(byte_ready), 32'd0);
                tick();
            end
            byte_valid = 1'b0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        check("loading_after_start", 32'(loading), 32'd1);
        check("byte_ready_in_write", 32'(byte_ready), 32'd1);
        check("error_cleared_by_start", 32'(error), 32'd0);
        k   = 0;
        cyc = 0;
        while (k < 16 && cyc < 200) begin
            byte_valid = tbl[i].toggle ? (cyc % 2 == 0) : 1'b1;
            byte_data  = byte_valid ? tbl[i].data[k] : 8'hC3;
            start      = tbl[i].noise && (k == 8);
            if (byte_valid) exp_q.push_back({4'(k), tbl[i].data[k]});
            tick();
            if (byte_valid) k++;
            cyc++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        check("all_bytes_sent", 32'(k), 32'd16);
        lat = 0;
        if (tbl[i].corrupt) begin
            tb_we    = 1'b1;
            tb_waddr = 4'd5;
            tb_wdata = 8'h01;
            tick();
            tb_we = 1'b0;
            lat   = 1;
        end
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check("done_latency", 32'(lat), VERIFY ? 32'd17 : 32'd0);
        check("loading_low_at_done", 32'(loading), 32'd0);
        check("error_at_done", 32'(error), 32'(tbl[i].exp_err));
        tick();
        check("done_single_pulse", 32'(done), 32'd0);
        tick();
        tick();
        check("error_sticky", 32'(error), 32'(tbl[i].exp_err));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        for (int a = 0; a < 16; a++) begin
            exp_b = (tbl[i].corrupt && a == 5) ? 8'h01 : tbl[i].data[a];
            check("ram_contents", {20'd0, 4'(a), mem[a]}, {20'd0, 4'(a), exp_b});
        end
        prev_err = tbl[i].exp_err;
        exp_q.delete();
    endtask

    task automatic run_reset_abort();
        fill(8'hA5);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            byte_valid = 1'b1;
            byte_data  = tbl[0].data[k];
            exp_q.push_back({4'(k), tbl[0].data[k]});
            tick();
        end
        byte_data = tbl[0].data[7];
        rst_n     = 1'b0;
        tick();
        check("abort_loading", 32'(loading), 32'd0);
        check("abort_ram_we", 32'(ram_we), 32'd0);
        check("abort_byte_ready", 32'(byte_ready), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        byte_valid = 1'b0;
        check("abort_queue_drained", 32'(exp_q.size()), 32'd0);
        for (int a = 0; a < 16; a++)
            check("abort_ram", {20'd0, 4'(a), mem[a]},
                  {20'd0, 4'(a), (a < 7) ? tbl[0].data[a] : 8'hA5});
        exp_q.delete();
    endtask

    initial begin
        for (int a = 0; a < 16; a++) tbl[0].data[a] = 8'h00;
        tbl[0].data[0]  = 8'h1F;
        tbl[0].data[1]  = 8'h4E;
        tbl[0].data[2]  = 8'hE0;
        tbl[0].data[3]  = 8'hFF;
        tbl[0].data[14] = 8'h0A;
        tbl[0].data[15] = 8'h0F;
        tbl[0].toggle = 1'b0; tbl[0].corrupt = 1'b0; tbl[0].noise = 1'b0; tbl[0].exp_err = 1'b0;
        tbl[1] = tbl[0];
        tbl[1].toggle = 1'b1;
        tbl[2] = tbl[0];
        tbl[2].corrupt = VERIFY;
        tbl[2].exp_err = VERIFY;
        for (int a = 0; a < 16; a++) tbl[3].data[a] = 8'(a * 37 + 11);
        tbl[3].toggle = 1'b0; tbl[3].corrupt = 1'b0; tbl[3].noise = 1'b1; tbl[3].exp_err = 1'b0;

        rst_n      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        tb_we      = 1'b0;
        tb_waddr   = 4'd0;
        tb_wdata   = 8'h00;
        prev_err   = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        check("reset_loading", 32'(loading), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_byte_ready", 32'(byte_ready), 32'd0);
        check("reset_ram_we", 32'(ram_we), 32'd0);
        check("reset_ram_addr", 32'(ram_addr), 32'd0);
        check("reset_ram_wdata", 32'(ram_wdata), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_load(i);
        run_reset_abort();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
